// File: rtl/factor_stream_engine.sv
// Streaming prime-factorization engine: trial division with a serial restoring divider.
// Optional FACT_ODD_STEP_EN: after d=2 the divisor visits only odd values.
module factor_stream_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] InN,
   output logic             Busy,
   output logic [WIDTH-1:0] Out,
   output logic             OutValid,
   input  logic             OutReady,
   output logic             OutLast
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_DIV   = 3'd2;
   localparam logic [2:0] S_EVAL  = 3'd3;
   localparam logic [2:0] S_EMIT  = 3'd4;

   localparam logic [WIDTH-1:0]   D_MAX   = '1;
   localparam logic [2*WIDTH-1:0] DSQ_MAX = '1;

   logic [2:0]         state_reg, state_next;
   logic [WIDTH-1:0]   n_reg, n_next;
   logic [WIDTH-1:0]   d_reg, d_next;
   logic [2*WIDTH-1:0] dsq_reg, dsq_next;
   logic [WIDTH-1:0]   q_reg, q_next;
   logic [WIDTH-1:0]   r_reg, r_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [WIDTH-1:0]   out_reg, out_next;
   logic               out_valid_reg, out_valid_next;
   logic               out_last_reg, out_last_next;
   logic               busy_reg, busy_next;

   // One restoring-division bit: shift the next dividend bit into the remainder.
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_trial;
   logic [WIDTH-1:0]   div_q;
   logic [WIDTH-1:0]   div_r;

   always_comb begin
      rem_shift = {r_reg, q_reg[WIDTH-1]};
      rem_trial = rem_shift - {1'b0, d_reg};
      if (!rem_trial[WIDTH]) begin
         div_r = rem_trial[WIDTH-1:0];
         div_q = {q_reg[WIDTH-2:0], 1'b1};
      end else begin
         div_r = rem_shift[WIDTH-1:0];
         div_q = {q_reg[WIDTH-2:0], 1'b0};
      end
   end

   // Next divisor and its square, kept incrementally so no multiplier is needed.
   logic [WIDTH-1:0]   step_d;
   logic [2*WIDTH-1:0] step_dsq;

   always_comb begin
      step_d   = d_reg;
      step_dsq = dsq_reg;
`ifdef FACT_ODD_STEP_EN
      if (d_reg == WIDTH'(2)) begin
         step_d   = WIDTH'(3);
         step_dsq = (2*WIDTH)'(9);
      end else if (d_reg > D_MAX - WIDTH'(2)) begin
         step_d   = D_MAX;
         step_dsq = DSQ_MAX;
      end else begin
         step_d   = d_reg + WIDTH'(2);
         step_dsq = dsq_reg + {{(WIDTH-2){1'b0}}, d_reg, 2'b00} + (2*WIDTH)'(4);
      end
`else
      if (d_reg == D_MAX) begin
         step_d   = D_MAX;
         step_dsq = DSQ_MAX;
      end else begin
         step_d   = d_reg + WIDTH'(1);
         step_dsq = dsq_reg + {{(WIDTH-1){1'b0}}, d_reg, 1'b1};
      end
`endif
   end

   always_comb begin
      state_next     = state_reg;
      n_next         = n_reg;
      d_next         = d_reg;
      dsq_next       = dsq_reg;
      q_next         = q_reg;
      r_next         = r_reg;
      cnt_next       = cnt_reg;
      out_next       = out_reg;
      out_valid_next = out_valid_reg;
      out_last_next  = out_last_reg;
      busy_next      = busy_reg;

      case (state_reg)
         S_IDLE: begin
            if (Start && !busy_reg) begin
               n_next    = InN;
               d_next    = WIDTH'(2);
               dsq_next  = (2*WIDTH)'(4);
               busy_next = 1'b1;
               if (InN < WIDTH'(2)) begin
                  out_next       = InN;
                  out_last_next  = 1'b1;
                  out_valid_next = 1'b1;
                  state_next     = S_EMIT;
               end else begin
                  state_next = S_CHECK;
               end
            end
         end

         S_CHECK: begin
            // Once d*d exceeds the cofactor, the cofactor itself is prime.
            if (dsq_reg > {{WIDTH{1'b0}}, n_reg}) begin
               out_next       = n_reg;
               out_last_next  = 1'b1;
               out_valid_next = 1'b1;
               state_next     = S_EMIT;
            end else begin
               q_next     = n_reg;
               r_next     = '0;
               cnt_next   = CW'(WIDTH);
               state_next = S_DIV;
            end
         end

         S_DIV: begin
            q_next = div_q;
            r_next = div_r;
            if (cnt_reg == CW'(1)) begin
               state_next = S_EVAL;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end

         S_EVAL: begin
            if (r_reg == '0) begin
               out_next       = d_reg;
               out_last_next  = 1'b0;
               out_valid_next = 1'b1;
               n_next         = q_reg;
               state_next     = S_EMIT;
            end else begin
               d_next     = step_d;
               dsq_next   = step_dsq;
               state_next = S_CHECK;
            end
         end

         S_EMIT: begin
            if (OutReady) begin
               out_valid_next = 1'b0;
               if (out_last_reg) begin
                  out_last_next = 1'b0;
                  busy_next     = 1'b0;
                  state_next    = S_IDLE;
               end else begin
                  state_next = S_CHECK;
               end
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         n_reg         <= '0;
         d_reg         <= '0;
         dsq_reg       <= '0;
         q_reg         <= '0;
         r_reg         <= '0;
         cnt_reg       <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         n_reg         <= n_next;
         d_reg         <= d_next;
         dsq_reg       <= dsq_next;
         q_reg         <= q_next;
         r_reg         <= r_next;
         cnt_reg       <= cnt_next;
         out_reg       <= out_next;
         out_valid_reg <= out_valid_next;
         out_last_reg  <= out_last_next;
         busy_reg      <= busy_next;
      end
   end

   assign Busy     = busy_reg;
   assign Out      = out_reg;
   assign OutValid = out_valid_reg;
   assign OutLast  = out_last_reg;

endmodule

// File: tb/tb_factor_stream_engine.sv
// Directed bench: 8-bit and 16-bit engines driven through factor streams, stalls and reset.
module tb_factor_stream_engine;

   logic        clk;
   logic        reset;

   logic        Start8, OutReady8;
   logic [7:0]  InN8;
   logic        Busy8, OutValid8, OutLast8;
   logic [7:0]  Out8;

   logic        Start16, OutReady16;
   logic [15:0] InN16;
   logic        Busy16, OutValid16, OutLast16;
   logic [15:0] Out16;

`ifdef FACT_ODD_STEP_EN
   localparam int EXP_BUSY_97    = 52;
   localparam int EXP_BUSY_65535 = 203;
`else
   localparam int EXP_BUSY_97    = 82;
   localparam int EXP_BUSY_65535 = 329;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic        sel;
   logic [31:0] o_out;
   logic        o_valid, o_last, o_busy;

   logic [31:0] beats [8];
   logic        lasts [8];
   int          nb;
   int          busy_cycles;

   factor_stream_engine #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .Start(Start8), .InN(InN8), .Busy(Busy8),
      .Out(Out8), .OutValid(OutValid8), .OutReady(OutReady8), .OutLast(OutLast8)
   );

   factor_stream_engine #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .Start(Start16), .InN(InN16), .Busy(Busy16),
      .Out(Out16), .OutValid(OutValid16), .OutReady(OutReady16), .OutLast(OutLast16)
   );

   assign o_out   = sel ? 32'(Out16) : 32'(Out8);
   assign o_valid = sel ? OutValid16 : OutValid8;
   assign o_last  = sel ? OutLast16 : OutLast8;
   assign o_busy  = sel ? Busy16 : Busy8;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start one factorization and drain it; rmode 0 = always ready, 1 = ready toggles every 3 cycles.
   task automatic run_stream(input logic [31:0] n, input int rmode, input int mid_start);
      logic        pv, pr, pl, rdy, done;
      logic [31:0] po;
      nb = 0;
      busy_cycles = 0;
      @(negedge clk);
      if (sel) begin Start16 = 1'b1; InN16 = n[15:0]; end
      else     begin Start8  = 1'b1; InN8  = n[7:0];  end
      OutReady8  = (rmode == 0);
      OutReady16 = (rmode == 0);
      @(negedge clk);
      Start8 = 1'b0;
      Start16 = 1'b0;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; po = '0; done = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         if (!o_busy) begin
            done = 1'b1;
         end else begin
            busy_cycles++;
            rdy = (rmode == 0) ? 1'b1 : (((cyc / 3) % 2) == 1);
            OutReady8  = rdy;
            OutReady16 = rdy;
            if (pv && !pr) begin
               check("stall_valid", o_valid, 1);
               check("stall_out", o_out, po);
               check("stall_last", o_last, pl);
            end
            if (o_valid && rdy && nb < 8) begin
               beats[nb] = o_out;
               lasts[nb] = o_last;
               nb++;
            end
            pv = o_valid; pr = rdy; po = o_out; pl = o_last;
            if (mid_start != 0 && cyc == 20) begin Start8 = 1'b1; InN8 = 8'd4; end
            if (mid_start != 0 && cyc == 21) Start8 = 1'b0;
            @(negedge clk);
         end
      end
      check("stream_done", done, 1);
      $display("stream N=%0d: %0d beats, busy %0d cycles", n, nb, busy_cycles);
   endtask

   initial begin
      reset = 1'b0;
      sel = 1'b0;
      Start8 = 0; InN8 = 0; OutReady8 = 0;
      Start16 = 0; InN16 = 0; OutReady16 = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", Busy8, 0);
      check("rst_valid", OutValid8, 0);
      check("rst_last", OutLast8, 0);
      check("rst_out", Out8, 0);
      check("rst_busy16", Busy16, 0);
      reset = 1'b1;
      @(negedge clk);

      // 12 = 2*2*3
      run_stream(12, 0, 0);
      check("n12_nb", nb, 3);
      check("n12_b0", beats[0], 2);
      check("n12_l0", lasts[0], 0);
      check("n12_b1", beats[1], 2);
      check("n12_l1", lasts[1], 0);
      check("n12_b2", beats[2], 3);
      check("n12_l2", lasts[2], 1);
      check("n12_busy", busy_cycles, 24);
      check("n12_idle_valid", OutValid8, 0);

      // 97 is prime
      run_stream(97, 0, 0);
      check("n97_nb", nb, 1);
      check("n97_b0", beats[0], 97);
      check("n97_l0", lasts[0], 1);
      check("n97_busy", busy_cycles, EXP_BUSY_97);

      run_stream(0, 0, 0);
      check("n0_nb", nb, 1);
      check("n0_b0", beats[0], 0);
      check("n0_l0", lasts[0], 1);
      check("n0_busy", busy_cycles, 1);

      run_stream(1, 0, 0);
      check("n1_nb", nb, 1);
      check("n1_b0", beats[0], 1);
      check("n1_l0", lasts[0], 1);
      check("n1_busy", busy_cycles, 1);

      // 255 = 3*5*17 with back-pressure and an ignored mid-run Start
      run_stream(255, 1, 1);
      check("n255_nb", nb, 3);
      check("n255_b0", beats[0], 3);
      check("n255_l0", lasts[0], 0);
      check("n255_b1", beats[1], 5);
      check("n255_l1", lasts[1], 0);
      check("n255_b2", beats[2], 17);
      check("n255_l2", lasts[2], 1);
      repeat (2) @(negedge clk);
      check("n255_stay_idle", Busy8, 0);
      check("n255_no_valid", OutValid8, 0);

      // 200: reset while the second trial is dividing
      OutReady8 = 1'b1;
      @(negedge clk);
      Start8 = 1'b1; InN8 = 8'd200;
      @(negedge clk);
      Start8 = 1'b0;
      repeat (15) @(negedge clk);
      check("n200_busy_pre", Busy8, 1);
      check("n200_out_pre", Out8, 2);
      reset = 1'b0;
      #1;
      check("n200_rst_busy", Busy8, 0);
      check("n200_rst_out", Out8, 0);
      check("n200_rst_valid", OutValid8, 0);
      check("n200_rst_last", OutLast8, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run_stream(6, 0, 0);
      check("n6_nb", nb, 2);
      check("n6_b0", beats[0], 2);
      check("n6_l0", lasts[0], 0);
      check("n6_b1", beats[1], 3);
      check("n6_l1", lasts[1], 1);

      // 16-bit engine: 65535 = 3*5*17*257
      sel = 1'b1;
      run_stream(65535, 0, 0);
      check("n65535_nb", nb, 4);
      check("n65535_b0", beats[0], 3);
      check("n65535_b1", beats[1], 5);
      check("n65535_b2", beats[2], 17);
      check("n65535_b3", beats[3], 257);
      check("n65535_l2", lasts[2], 0);
      check("n65535_l3", lasts[3], 1);
      check("n65535_busy", busy_cycles, EXP_BUSY_65535);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
